// File: rtl/fwd_ctrl.sv
// fwd_ctrl: EX/MEM forwarding-select and load-use stall controller for one issue slot.
// Define FWD_WB_BYPASS_EN to forward MEM-stage results (select 2) instead of stalling on them.
module fwd_ctrl #(
   parameter int AWIDTH = 5,
   parameter int CWIDTH = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [AWIDTH-1:0] i_rs,
   input  logic [AWIDTH-1:0] i_rt,
   input  logic [AWIDTH-1:0] i_rd,
   input  logic              i_reg_write,
   input  logic              i_is_load,
   input  logic              i_flush,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic              o_ex_valid,
   output logic [CWIDTH-1:0] o_stall_cnt
);
   typedef enum logic {RUN, STALL} state_t;
   state_t state_q, state_d;
   logic e_valid_q, e_valid_d, e_wr_q, e_wr_d, e_load_q, e_load_d;
   logic m_valid_q, m_valid_d, m_wr_q, m_wr_d;
   logic [AWIDTH-1:0] e_dest_q, e_dest_d, m_dest_q, m_dest_d;
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic ex_valid_q, ex_valid_d;
   logic [CWIDTH-1:0] cnt_q, cnt_d;
   logic a_e, b_e, a_m, b_m, hazard, m_block, accept, stall;
   logic [1:0] sel_a, sel_b;

   function automatic logic live(input logic v, input logic w,
                                 input logic [AWIDTH-1:0] d, input logic [AWIDTH-1:0] s);
      return v & w & (d == s) & (s != '0);
   endfunction

   assign a_e = live(e_valid_q, e_wr_q, e_dest_q, i_rs);
   assign b_e = live(e_valid_q, e_wr_q, e_dest_q, i_rt);
   assign a_m = live(m_valid_q, m_wr_q, m_dest_q, i_rs);
   assign b_m = live(m_valid_q, m_wr_q, m_dest_q, i_rt);
   assign hazard = e_load_q & (a_e | b_e);

`ifdef FWD_WB_BYPASS_EN
   assign m_block = 1'b0;
   assign sel_a = a_e ? 2'd1 : (a_m ? 2'd2 : 2'd0);
   assign sel_b = b_e ? 2'd1 : (b_m ? 2'd2 : 2'd0);
`else
   // MEM results are not forwarded: wait until the producer has written back.
   assign m_block = a_m | b_m;
   assign sel_a = a_e ? 2'd1 : 2'd0;
   assign sel_b = b_e ? 2'd1 : 2'd0;
`endif

   assign o_ready = ~hazard & ~m_block & ~i_flush;
   assign accept  = i_valid & o_ready;
   assign stall   = i_valid & ~i_flush & ~o_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     state_d = stall ? STALL : RUN;
         STALL:   state_d = stall ? STALL : RUN;
         default: state_d = RUN;
      endcase
      e_valid_d  = accept;
      e_wr_d     = accept & i_reg_write;
      e_load_d   = accept & i_is_load;
      e_dest_d   = accept ? i_rd : '0;
      // A flush squashes EX before it shifts, so MEM receives a bubble.
      m_valid_d  = e_valid_q & ~i_flush;
      m_wr_d     = e_wr_q;
      m_dest_d   = e_dest_q;
      fwd_a_d    = accept ? sel_a : 2'd0;
      fwd_b_d    = accept ? sel_b : 2'd0;
      ex_valid_d = accept;
      cnt_d      = (stall & ~&cnt_q) ? cnt_q + CWIDTH'(1) : cnt_q;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= RUN;
         e_valid_q  <= 1'b0;
         e_wr_q     <= 1'b0;
         e_load_q   <= 1'b0;
         e_dest_q   <= '0;
         m_valid_q  <= 1'b0;
         m_wr_q     <= 1'b0;
         m_dest_q   <= '0;
         fwd_a_q    <= 2'd0;
         fwd_b_q    <= 2'd0;
         ex_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         e_valid_q  <= e_valid_d;
         e_wr_q     <= e_wr_d;
         e_load_q   <= e_load_d;
         e_dest_q   <= e_dest_d;
         m_valid_q  <= m_valid_d;
         m_wr_q     <= m_wr_d;
         m_dest_q   <= m_dest_d;
         fwd_a_q    <= fwd_a_d;
         fwd_b_q    <= fwd_b_d;
         ex_valid_q <= ex_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_fwd_a     = fwd_a_q;
   assign o_fwd_b     = fwd_b_q;
   assign o_ex_valid  = ex_valid_q;
   assign o_stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed vectors for fwd_ctrl; expected selects queued on issue, checked as EX presents them.
module tb_fwd_ctrl;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef FWD_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   logic i_valid = 1'b0, i_reg_write = 1'b0, i_is_load = 1'b0, i_flush = 1'b0;
   logic [AW-1:0] i_rs = '0, i_rt = '0, i_rd = '0;
   logic o_ready, o_ex_valid;
   logic [1:0] o_fwd_a, o_fwd_b;
   logic [CW-1:0] o_stall_cnt;

   int checks = 0;
   int fails = 0;
   int exp_cnt = 0;
   logic [3:0] exp_q[$];
   logic [3:0] e;

   fwd_ctrl #(.AWIDTH(AW), .CWIDTH(CW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_reg_write(i_reg_write),
      .i_is_load(i_is_load), .i_flush(i_flush), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
      .o_ex_valid(o_ex_valid), .o_stall_cnt(o_stall_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per real instruction in EX; bubbles must show select 0.
   always @(negedge i_clk) begin
      if (i_rst) begin
         if (o_ex_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_issue: EX valid with fwd_a=%0d fwd_b=%0d, nothing queued", o_fwd_a, o_fwd_b);
            end else begin
               e = exp_q.pop_front();
               chk("fwd_a", {30'd0, o_fwd_a}, {30'd0, e[3:2]});
               chk("fwd_b", {30'd0, o_fwd_b}, {30'd0, e[1:0]});
            end
         end else begin
            chk("bubble_fwd", {28'd0, o_fwd_a, o_fwd_b}, 32'd0);
         end
      end
   end

   task automatic drive(input int rs, input int rt, input int rd, input bit wr, input bit ld);
      i_valid = 1'b1;
      i_rs = AW'(rs);
      i_rt = AW'(rt);
      i_rd = AW'(rd);
      i_reg_write = wr;
      i_is_load = ld;
   endtask

   task automatic issue(input int rs, input int rt, input int rd, input bit wr, input bit ld,
                        input int stalls, input int a, input int b);
      int n;
      n = 0;
      drive(rs, rt, rd, wr, ld);
      #1;
      while (!o_ready && n < 10) begin
         n++;
         @(posedge i_clk);
         #2;
         chk("stall_bubble", {31'd0, o_ex_valid}, 32'd0);
      end
      chk("stall_cycles", n, stalls);
      if (o_ready) exp_q.push_back({a[1:0], b[1:0]});
      @(posedge i_clk);
      #1;
      exp_cnt = (exp_cnt + stalls > CMAX) ? CMAX : exp_cnt + stalls;
      chk("stall_cnt", {{(32-CW){1'b0}}, o_stall_cnt}, exp_cnt);
   endtask

   task automatic idle(input int k);
      i_valid = 1'b0;
      repeat (k) @(posedge i_clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_ex_valid", {31'd0, o_ex_valid}, 32'd0);
      chk("rst_fwd", {28'd0, o_fwd_a, o_fwd_b}, 32'd0);
      chk("rst_cnt", {{(32-CW){1'b0}}, o_stall_cnt}, 32'd0);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      // add r3<-r1,r2 ; sub r4<-r3,r5
      issue(1, 2, 3, 1, 0, 0, 0, 0);
      issue(3, 5, 4, 1, 0, 0, 1, 0);
      idle(3);
      // add r3 ; unrelated ; reader of r3 on rt
      issue(1, 2, 3, 1, 0, 0, 0, 0);
      issue(8, 9, 6, 1, 0, 0, 0, 0);
      issue(11, 3, 10, 1, 0, BYP ? 0 : 1, 0, BYP ? 2 : 0);
      idle(3);
      // lw r7 ; reader of r7 on rs
      issue(1, 0, 7, 1, 1, 0, 0, 0);
      issue(7, 2, 8, 1, 0, BYP ? 1 : 2, BYP ? 2 : 0, 0);
      idle(3);
      // r0 destination and non-writing producers never match
      issue(1, 2, 0, 1, 0, 0, 0, 0);
      issue(0, 0, 5, 1, 0, 0, 0, 0);
      issue(1, 2, 9, 0, 0, 0, 0, 0);
      issue(9, 9, 10, 1, 0, 0, 0, 0);
      issue(1, 0, 12, 0, 1, 0, 0, 0);
      issue(12, 12, 13, 1, 0, 0, 0, 0);
      idle(3);
      // flush in the load-use stall cycle squashes the load out of the pipe
      issue(1, 0, 7, 1, 1, 0, 0, 0);
      drive(7, 0, 8, 1, 0);
      i_flush = 1'b1;
      #1;
      chk("flush_ready", {31'd0, o_ready}, 32'd0);
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      chk("flush_ex_valid", {31'd0, o_ex_valid}, 32'd0);
      chk("flush_cnt", {{(32-CW){1'b0}}, o_stall_cnt}, exp_cnt);
      issue(7, 0, 8, 1, 0, 0, 0, 0);
      idle(3);
      // build up stalls, then reset in the middle of one
      while (exp_cnt < 4) begin
         issue(1, 0, 7, 1, 1, 0, 0, 0);
         issue(7, 2, 8, 1, 0, BYP ? 1 : 2, BYP ? 2 : 0, 0);
      end
      issue(1, 0, 7, 1, 1, 0, 0, 0);
      drive(7, 2, 8, 1, 0);
      #1;
      chk("midstall_ready", {31'd0, o_ready}, 32'd0);
      @(posedge i_clk);
      #1;
      exp_cnt++;
      chk("cnt_before_reset", {{(32-CW){1'b0}}, o_stall_cnt}, exp_cnt);
      i_rst = 1'b0;
      #1;
      chk("reset_ready", {31'd0, o_ready}, 32'd1);
      chk("reset_ex_valid", {31'd0, o_ex_valid}, 32'd0);
      chk("reset_fwd", {28'd0, o_fwd_a, o_fwd_b}, 32'd0);
      chk("reset_cnt", {{(32-CW){1'b0}}, o_stall_cnt}, 32'd0);
      i_valid = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      exp_cnt = 0;
      idle(2);
      // continuous load-use pairs drive the counter into saturation
      for (int i = 0; i < 17; i++) begin
         issue(1, 0, 7, 1, 1, 0, 0, 0);
         issue(7, 2, 8, 1, 0, BYP ? 1 : 2, BYP ? 2 : 0, 0);
      end
      chk("cnt_saturated", {{(32-CW){1'b0}}, o_stall_cnt}, CMAX);
      idle(3);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and load-use hazard controller for one issue slot of the integer pipeline. It tracks the destination registers of the two older instructions in the EX and MEM stages and accepts a new instruction through a valid/ready handshake. For each accepted instruction it produces the registered 2-bit operand-select codes for the EX-stage forwarding muxes: 0 = register-file data, 1 = ALU value, 2 = write-back data. When a load result cannot be forwarded in time, it stalls the issue stage and injects bubbles.

## Interface
Parameters:
- AWIDTH, 5, register-address width.
- CWIDTH, 16, width of the stall-cycle counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_valid  input  1  issue stage presents an instruction.
- o_ready  output  1  instruction accepted this cycle when i_valid & o_ready.
- i_rs  input  AWIDTH  source A register.
- i_rt  input  AWIDTH  source B register.
- i_rd  input  AWIDTH  destination register.
- i_reg_write  input  1  instruction writes i_rd.
- i_is_load  input  1  instruction is a load; result available only at write-back.
- i_flush  input  1  squash the instruction in EX and any issue this cycle.
- o_fwd_a  output  2  select for operand A in EX (0 data, 1 alu_value, 2 write_back_data).
- o_fwd_b  output  2  select for operand B in EX.
- o_ex_valid  output  1  EX stage holds a real instruction (0 = bubble).
- o_stall_cnt  output  CWIDTH  saturating count of stall cycles.

## Operation
- Tracker E: valid, dest, wr, load for the instruction in EX. Tracker M: the same fields for the instruction in MEM.
- Every cycle, M <= E. E <= the accepted instruction, or a bubble (valid=0) if nothing was accepted.
- Live match on a source s against tracker X: X.valid & X.wr & (X.dest == s) & (s != 0).
- Hazard: live match on rs or rt against E with E.load = 1.
- o_ready = ~hazard & ~i_flush. With FWD_WB_BYPASS_EN undefined, a live match against M also clears o_ready.
- On accept, each select is registered as follows: E match -> 1; else M match -> 2; else 0. The E match takes priority because it is the younger producer.
- States:
  - RUN: no hazard; go to STALL when a hazard is present and i_valid = 1.
  - STALL: a bubble enters E and o_stall_cnt increments; return to RUN once the hazard clears.
- i_valid = 0 is never a stall and does not count.
- i_flush:
  - E is invalidated before the shift, so M receives a bubble.
  - A bubble is loaded into E and the FSM returns to RUN.
  - o_fwd_a/b are forced to 0.
- A bubble or rejected cycle drives o_fwd_a/b = 0 and o_ex_valid = 0.
- o_stall_cnt saturates at all ones and never wraps.

## Timing
- Reset: o_fwd_a = o_fwd_b = 0, o_ex_valid = 0, o_stall_cnt = 0, trackers invalid, FSM in RUN. o_ready is combinational and is therefore 1 during reset (no live matches).
- o_ready is combinational from i_rs, i_rt, i_flush and the trackers. o_fwd_a/b and o_ex_valid are registered and valid in the cycle after accept, aligned with the instruction in EX.
- Load-use latency:
  - With bypass: dependent instruction sees 1 stall cycle, then select 2.
  - Without bypass: 2 stall cycles, then select 0.
- Reset asserted mid-stall returns everything to reset values immediately. No partial state survives.

## Configuration
- FWD_WB_BYPASS_EN defined: M-stage matches forward with select 2. Stalls occur only for load-use on E.
- FWD_WB_BYPASS_EN undefined: select 2 is never produced. Any M-stage match stalls until the producer has written back, then select 0 is issued.

## Test plan
- Back-to-back ALU ops `add r3 <- r1,r2` then `sub r4 <- r3,r5` -> no stall; o_fwd_a = 1, o_fwd_b = 0 in the cycle after the second accept.
- `add r3` then an unrelated instruction, then a reader of r3 on rt -> o_fwd_b = 2 (bypass on); without bypass, o_ready is low for 1 cycle, then o_fwd_b = 0.
- `lw r7` followed immediately by a reader of r7 on rs -> o_ready low for 1 cycle, o_ex_valid = 0 bubble, then o_fwd_a = 2. o_stall_cnt = 1 (2 and select 0 without bypass).
- Writes to r0, or i_reg_write = 0 producers, followed by readers of the same register -> selects stay 0 and no stall.
- i_flush during a load-use stall -> FSM returns to RUN, o_ex_valid = 0, o_fwd = 0. The next instruction issues with no stall unless M still matches.
- Assert i_rst mid-stall with o_stall_cnt = 5 -> all outputs return to 0 and o_ready = 1 while in reset. Also force the counter near all ones with continuous stalls and confirm it holds at all ones.
